// File: rtl/bus_arbiter_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_4_pkg
// Description : Shared types and constants for the 4-requester round-robin
//               bus arbiter (state encoding, requester indices, data width).
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_4_pkg;

    // Arbiter sequencer states
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Requester slot assignment on the shared write/transfer port
    localparam logic [1:0] REQ_ALU  = 2'd0;
    localparam logic [1:0] REQ_LOAD = 2'd1;
    localparam logic [1:0] REQ_PC4  = 2'd2;
    localparam logic [1:0] REQ_IMM  = 2'd3;

    // Default requester word width
    localparam int DW_DEFAULT = 32;

    // Binary index to one-hot grant vector
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : bus_arbiter_4_pkg
`default_nettype wire

// File: rtl/bus_arbiter_4_rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_4
// Description : Combinational round-robin picker. Scans requesters starting
//               one past the last winner and wrapping, so the last winner
//               has the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    // Walk offsets 4 down to 1 so the nearest requester after last wins
    always_comb begin
        logic [1:0] w_cand;
        valid  = 1'b0;
        idx    = last;
        w_cand = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = last + 2'(k);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : rr_pick_4
`default_nettype wire

// File: rtl/bus_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_4
// Description : Four-requester round-robin arbiter for the shared 32-bit
//               write/transfer port. Captures the winning word into an output
//               register, drives the registered select code and holds the
//               transfer until the consumer accepts it.
//               Optional feature macro: ARB_LOCK_EN (requester lock/ownership).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [DW-1:0] data3,
    input  logic [3:0]    lock,
    output logic [3:0]    ack,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    arb_state_t    r_state;
    logic [1:0]    r_last;

    logic          w_rr_valid;
    logic [1:0]    w_rr_idx;
    logic          w_win_valid;
    logic [1:0]    w_win_idx;
    logic [DW-1:0] w_win_data;

    rr_pick_4 u_rr_pick (
        .req   (req),
        .last  (r_last),
        .valid (w_rr_valid),
        .idx   (w_rr_idx)
    );

`ifdef ARB_LOCK_EN
    logic          r_owner_valid;
    logic [1:0]    r_owner;
    logic          w_owner_hit;

    // A still-requesting lock owner overrides the round-robin choice
    assign w_owner_hit = r_owner_valid & req[r_owner];
    assign w_win_valid = w_owner_hit | w_rr_valid;
    assign w_win_idx   = w_owner_hit ? r_owner : w_rr_idx;
`else
    logic          w_lock_unused;

    // Lock input is accepted but has no effect in the pure round-robin build
    assign w_lock_unused = ^lock;
    assign w_win_valid   = w_rr_valid;
    assign w_win_idx     = w_rr_idx;
`endif

    // Select the winning requester's word for capture
    always_comb begin
        w_win_data = data0;
        case (w_win_idx)
            REQ_ALU:  w_win_data = data0;
            REQ_LOAD: w_win_data = data1;
            REQ_PC4:  w_win_data = data2;
            REQ_IMM:  w_win_data = data3;
            default:  w_win_data = data0;
        endcase
    end

    // Accept strobe goes back only to the granted requester
    assign ack = gnt & {4{out_valid & out_ready}};

    // Grant sequencer: capture in IDLE, hold in BUSY until the consumer accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            gnt           <= 4'b0000;
            sel           <= 2'd0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            r_last        <= 2'd3;
`ifdef ARB_LOCK_EN
            r_owner_valid <= 1'b0;
            r_owner       <= 2'd0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
`ifdef ARB_LOCK_EN
                    // Owner that stopped requesting gives up its lock now
                    if (r_owner_valid && !req[r_owner]) begin
                        r_owner_valid <= 1'b0;
                    end
`endif
                    if (w_win_valid) begin
                        gnt       <= onehot4(w_win_idx);
                        sel       <= w_win_idx;
                        out_data  <= w_win_data;
                        out_valid <= 1'b1;
                        r_state   <= ARB_BUSY;
                    end else begin
                        gnt       <= 4'b0000;
                        out_valid <= 1'b0;
                    end
                end
                ARB_BUSY: begin
                    if (out_ready) begin
                        r_last    <= sel;
                        out_valid <= 1'b0;
                        gnt       <= 4'b0000;
                        r_state   <= ARB_IDLE;
`ifdef ARB_LOCK_EN
                        r_owner_valid <= lock[sel];
                        r_owner       <= sel;
`endif
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : bus_arbiter_4
`default_nettype wire

// File: doc/bus_arbiter_4.md
# bus_arbiter_4

Four-requester round-robin arbiter that shares one 32-bit write/transfer port among the KGP-RISC datapath sources (e.g. ALU result, load data, PC+4, immediate). It picks one requester, captures its word into an output register, drives the 2-bit select code for the downstream 4:1 32-bit select, and holds the transfer until the consumer accepts it. It sits between the source stages and the single shared consumer, replacing a hard-wired select with a fair, handshaked sequencer.

## Interface
- DW, 32, data width of each requester word and of out_data
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  4  req[i]=1: requester i has a valid word on its data bus
- data0..data3  in  DW each  requester words; held stable while req[i]=1 and ack[i]=0
- lock  in  4  lock[i]=1: requester i wants to keep ownership after this transfer (used only with ARB_LOCK_EN)
- ack  out  4  one-hot, combinational: ack[i]=out_valid & out_ready & gnt[i]
- gnt  out  4  one-hot registered grant; 0 when idle
- sel  out  2  registered binary index of granted requester
- out_valid  out  1  registered; out_data holds a granted word
- out_data  out  DW  registered captured word
- out_ready  in  1  consumer accepts out_data when out_valid=1

## Operation
- Two states: IDLE, BUSY. Reset: state=IDLE, gnt=0, sel=0, out_valid=0, out_data=0, last=3 (requester 0 has top priority first), lock owner invalid.
- IDLE, req=0: stay IDLE, outputs unchanged except out_valid=0, gnt=0.
- IDLE, req!=0: winner = first i with req[i]=1 scanning last+1, last+2, last+3, last (mod 4). Register gnt=onehot(winner), sel=winner, out_data=data[winner], out_valid=1; go BUSY.
- BUSY: gnt, sel, out_data, out_valid held. req changes ignored (word already captured). When out_ready=1: ack[sel]=1 that cycle, last<=sel, out_valid<=0, gnt<=0, go IDLE.
- Requester drops req on the edge where it sees ack; a requester with another word keeps req high and updates data on that edge.
- One mandatory IDLE cycle between transfers: peak throughput one word per 2 cycles.
- rst in any state returns to reset values on the next edge; in-flight word discarded, no ack issued.

## Timing
- req sampled at edge N in IDLE -> out_valid=1, sel/gnt/out_data valid after edge N.
- out_ready=1 in cycle M (BUSY) -> ack high during cycle M, out_valid=0 after edge M.
- Min req-to-ack: 1 cycle (out_ready tied high). Min spacing between acks: 2 cycles.
- out_ready while out_valid=0 has no effect.
- All four req high continuously: grants 0,1,2,3,0,... from reset.

## Configuration
- ARB_LOCK_EN defined: if accepted with lock[sel]=1, sel becomes lock owner; in IDLE, if owner valid and req[owner]=1, owner wins regardless of round-robin. Ownership cleared when owner's transfer is accepted with lock=0, or owner's req=0 in an IDLE cycle (then normal round-robin that same cycle). last still updates to owner on each accept.
- Not defined: lock port present but ignored; pure round-robin.

## Structure
- Shared package: state encoding (ARB_IDLE=1'b0, ARB_BUSY=1'b1), requester index constants (REQ_ALU..REQ_IMM = 0..3), DW default.
- One sub-module: rr_pick_4 (combinational: req[3:0], last[1:0] -> valid, idx[1:0]); FSM, registers and data capture in bus_arbiter_4.

## Test plan
- Reset then req=4'b0100, data2=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, sel=2, gnt=4'b0100, out_data=32'hDEADBEEF, ack=4'b0100 same cycle.
- req=4'b1111 held, out_ready=1, distinct data -> acks in order 0,1,2,3,0 every 2 cycles, out_data matching each.
- Backpressure: grant requester 1, out_ready=0 for 5 cycles, change data1 and drop req[1] meanwhile -> out_data, sel=1, out_valid stable; ack[1] only on cycle out_ready rises.
- rst asserted while BUSY with out_ready=0 -> next cycle out_valid=0, gnt=0, no ack; then req=4'b1000 -> requester 3 granted (last=3 search starts at 0, only 3 requesting).
- ARB_LOCK_EN: req=4'b0011, lock=4'b0001 for 3 transfers -> grants 0,0,0; lock[0]=0 on third -> fourth grant is 1.
- ARB_LOCK_EN absent, same stimulus -> grants alternate 0,1,0,1.
